// File: rtl/fu_context_loader_if.sv
// Serial configuration handshake between a bitstream source and the context loader.
interface fu_context_loader_if;
  logic cfg_valid;
  logic cfg_data;
  logic cfg_ready;
  logic cfg_abort;

  modport master (output cfg_valid, output cfg_data, output cfg_abort, input cfg_ready);
  modport slave  (input cfg_valid, input cfg_data, input cfg_abort, output cfg_ready);
endinterface

// File: rtl/fu_context_loader.sv
// Double-buffered opcode context loader for the CGRA function unit: serial frames
// shift into a shadow bank, commit into the active bank, and run-time stepping drives select.
module fu_context_loader #(
  parameter int SEL_W   = 4,
  parameter int NUM_CTX = 4,
  parameter int MAX_OP  = 9,
  localparam int CTX_W  = $clog2(NUM_CTX)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  fu_context_loader_if.slave       cfg,
  output logic                     cfg_done,
  output logic                     cfg_err,
  output logic                     configured,
  input  logic                     run,
  input  logic                     step,
  output logic [CTX_W-1:0]         ctx_idx,
  output logic [SEL_W-1:0]         select
);

  localparam int F     = NUM_CTX * SEL_W;
  localparam int CNT_W = $clog2(F);
  localparam logic [SEL_W-1:0] MAX_OP_C = SEL_W'(MAX_OP);
  localparam logic [CNT_W-1:0] LAST     = CNT_W'(F - 1);

  typedef enum logic [1:0] {EMPTY, LOADING, ARMED} state_t;

  state_t                        state_q, state_nx;
  logic [CNT_W-1:0]              cnt_q;
  logic [F-2:0]                  shadow_q;
  logic [F-1:0]                  frame_bits;
  logic [NUM_CTX-1:0][SEL_W-1:0] frame, clean, active_q;
  logic [NUM_CTX-1:0]            bad;
  logic                          xfer, commit;

  // The shadow only holds F-1 bits; the final bit is taken straight off the wire at commit.
  assign frame_bits    = {cfg.cfg_data, shadow_q};
  assign frame         = frame_bits;
  assign cfg.cfg_ready = !cfg.cfg_abort;

  for (genvar i = 0; i < NUM_CTX; i++) begin : g_ctx
    assign bad[i]   = frame[i] > MAX_OP_C;
    assign clean[i] = bad[i] ? '0 : frame[i];
  end

  always_comb begin
    state_nx = state_q;
    xfer     = 1'b0;
    commit   = 1'b0;
    if (cfg.cfg_abort) begin
      state_nx = configured ? ARMED : EMPTY;
    end else if (cfg.cfg_valid) begin
      xfer     = 1'b1;
      commit   = (cnt_q == LAST);
      state_nx = commit ? ARMED : LOADING;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= EMPTY;
      cnt_q      <= '0;
      shadow_q   <= '0;
      active_q   <= '0;
      cfg_done   <= 1'b0;
      cfg_err    <= 1'b0;
      configured <= 1'b0;
      ctx_idx    <= '0;
    end else begin
      state_q  <= state_nx;
      cfg_done <= commit;
      if (cfg.cfg_abort) begin
        cnt_q    <= '0;
        shadow_q <= '0;
      end else if (xfer) begin
        shadow_q <= frame_bits[F-1:1];
        cnt_q    <= commit ? '0 : cnt_q + CNT_W'(1);
      end
      if (commit) begin
        active_q   <= clean;
        configured <= 1'b1;
        if (|bad) cfg_err <= 1'b1;
      end
      // Commit restarts the sequence even if a step lands on the same edge.
      if (commit)
        ctx_idx <= '0;
      else if (run && step)
        ctx_idx <= ctx_idx + CTX_W'(1);
    end
  end

  assign select = active_q[ctx_idx];

endmodule

// File: tb/tb_fu_context_loader.sv
// Directed bench for fu_context_loader: hand-computed banks, stepping, abort, sanitising, async reset.
module tb_fu_context_loader;
  logic       clk = 1'b0;
  logic       rst_n;
  logic       cfg_done, cfg_err, configured;
  logic       run, step;
  logic [1:0] ctx_idx;
  logic [3:0] select;
  int         n_cmp = 0;
  int         n_bad = 0;

  fu_context_loader_if cfg_if ();

  fu_context_loader dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cfg        (cfg_if.slave),
    .cfg_done   (cfg_done),
    .cfg_err    (cfg_err),
    .configured (configured),
    .run        (run),
    .step       (step),
    .ctx_idx    (ctx_idx),
    .select     (select)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [15:0] w);
    for (int k = 0; k < 16; k++) begin
      cfg_if.cfg_valid = 1'b1;
      cfg_if.cfg_data  = w[k];
      tick();
      if (k < 15) check("done_early", {31'd0, cfg_done}, 32'd0);
    end
    cfg_if.cfg_valid = 1'b0;
    cfg_if.cfg_data  = 1'b0;
  endtask

  initial begin
    logic [3:0] bank_a [4];
    logic [15:0] w;
    int exp_idx;
    bank_a = '{4'd1, 4'd2, 4'd9, 4'd4};

    rst_n = 1'b0;
    cfg_if.cfg_valid = 1'b0;
    cfg_if.cfg_data  = 1'b0;
    cfg_if.cfg_abort = 1'b0;
    run  = 1'b0;
    step = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
    repeat (5) tick();
    check("rst_select", {28'd0, select}, 32'd0);
    check("rst_idx",    {30'd0, ctx_idx}, 32'd0);
    check("rst_conf",   {31'd0, configured}, 32'd0);
    check("rst_err",    {31'd0, cfg_err}, 32'd0);
    check("rst_ready",  {31'd0, cfg_if.cfg_ready}, 32'd1);
    check("rst_done",   {31'd0, cfg_done}, 32'd0);

    // Basic load then step through 1,2,9,4 and wrap
    send_frame(16'h4921);
    check("c1_done",   {31'd0, cfg_done}, 32'd1);
    check("c1_select", {28'd0, select}, 32'd1);
    check("c1_idx",    {30'd0, ctx_idx}, 32'd0);
    check("c1_conf",   {31'd0, configured}, 32'd1);
    check("c1_err",    {31'd0, cfg_err}, 32'd0);
    tick();
    check("c1_done_1cyc", {31'd0, cfg_done}, 32'd0);
    run = 1'b1; step = 1'b1;
    tick(); check("step1", {28'd0, select}, 32'd2);
    tick(); check("step2", {28'd0, select}, 32'd9);
    tick(); check("step3", {28'd0, select}, 32'd4);
    tick(); check("step_wrap", {28'd0, select}, 32'd1);
    check("step_wrap_idx", {30'd0, ctx_idx}, 32'd0);
    run = 1'b0;
    tick(); check("step_norun", {30'd0, ctx_idx}, 32'd0);
    step = 1'b0;

    // Load with gapped valid while the old bank keeps stepping
    w = 16'h4921;
    exp_idx = 0;
    run = 1'b1; step = 1'b1;
    for (int c = 0; c < 32; c++) begin
      cfg_if.cfg_valid = (c % 2 == 0);
      cfg_if.cfg_data  = w[c/2];
      tick();
      if (c == 30) begin
        exp_idx = 0;
        check("gap_commit_done", {31'd0, cfg_done}, 32'd1);
        check("gap_commit_idx",  {30'd0, ctx_idx}, 32'd0);
        check("gap_commit_sel",  {28'd0, select}, 32'd1);
      end else begin
        exp_idx = (exp_idx + 1) % 4;
        check("gap_idx",  {30'd0, ctx_idx}, exp_idx);
        check("gap_sel",  {28'd0, select}, {28'd0, bank_a[exp_idx]});
        check("gap_done", {31'd0, cfg_done}, 32'd0);
      end
    end
    cfg_if.cfg_valid = 1'b0;
    run = 1'b0; step = 1'b0;
    tick();

    // Illegal opcode sanitised to 0, sticky error
    send_frame(16'h0F35);
    check("san_err", {31'd0, cfg_err}, 32'd1);
    check("san_c0",  {28'd0, select}, 32'd5);
    run = 1'b1; step = 1'b1;
    tick(); check("san_c1", {28'd0, select}, 32'd3);
    tick(); check("san_c2", {28'd0, select}, 32'd0);
    tick(); check("san_c3", {28'd0, select}, 32'd0);
    run = 1'b0; step = 1'b0;
    send_frame(16'h1111);
    check("err_sticky", {31'd0, cfg_err}, 32'd1);
    check("clean_c0",   {28'd0, select}, 32'd1);

    // Abort mid-frame, then a full realigned frame
    send_frame(16'h4921);
    check("ab_pre_sel", {28'd0, select}, 32'd1);
    for (int k = 0; k < 7; k++) begin
      cfg_if.cfg_valid = 1'b1;
      cfg_if.cfg_data  = 1'b1;
      tick();
    end
    cfg_if.cfg_abort = 1'b1;
    #1;
    check("ab_ready", {31'd0, cfg_if.cfg_ready}, 32'd0);
    tick();
    check("ab_done", {31'd0, cfg_done}, 32'd0);
    check("ab_sel",  {28'd0, select}, 32'd1);
    check("ab_idx",  {30'd0, ctx_idx}, 32'd0);
    check("ab_conf", {31'd0, configured}, 32'd1);
    cfg_if.cfg_abort = 1'b0;
    cfg_if.cfg_valid = 1'b0;
    #1;
    check("ab_ready_back", {31'd0, cfg_if.cfg_ready}, 32'd1);
    send_frame(16'h0876);
    check("ab_new_done", {31'd0, cfg_done}, 32'd1);
    check("ab_new_c0",   {28'd0, select}, 32'd6);
    run = 1'b1; step = 1'b1;
    tick(); check("ab_new_c1", {28'd0, select}, 32'd7);
    tick(); check("ab_new_c2", {28'd0, select}, 32'd8);
    tick(); check("ab_new_c3", {28'd0, select}, 32'd0);

    // Asynchronous reset mid-frame and mid-run
    for (int k = 0; k < 5; k++) begin
      cfg_if.cfg_valid = 1'b1;
      cfg_if.cfg_data  = 1'b1;
      tick();
    end
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_select", {28'd0, select}, 32'd0);
    check("arst_idx",    {30'd0, ctx_idx}, 32'd0);
    check("arst_conf",   {31'd0, configured}, 32'd0);
    check("arst_err",    {31'd0, cfg_err}, 32'd0);
    check("arst_done",   {31'd0, cfg_done}, 32'd0);
    check("arst_ready",  {31'd0, cfg_if.cfg_ready}, 32'd1);
    cfg_if.cfg_valid = 1'b0;
    run = 1'b0; step = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    send_frame(16'h4921);
    check("post_done", {31'd0, cfg_done}, 32'd1);
    check("post_sel",  {28'd0, select}, 32'd1);
    check("post_err",  {31'd0, cfg_err}, 32'd0);
    run = 1'b1; step = 1'b1;
    tick(); check("post_step", {28'd0, select}, 32'd2);
    run = 1'b0; step = 1'b0;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/fu_context_loader.md
# fu_context_loader

Configuration-side front end for the CGRA 32-bit function unit. It receives a serial configuration bitstream through a valid/ready handshake and assembles it into a bank of NUM_CTX opcode contexts. At run time it sequences through those contexts and drives the function unit's 4-bit operation select. Configuration is double-buffered, so a new frame can be shifted in while the current bank keeps driving `select`.

## Interface
- SEL_W, 4, opcode width; matches the function-unit select.
- NUM_CTX, 4, contexts per frame; power of two, 2..16.
- MAX_OP, 9, highest legal opcode: 0 add, 1 mul, 2 sub, 3 div, 4 and, 5 or, 6 xor, 7 shl, 8 ashr, 9 lshr.
- clk  in  1  single clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- cfg_valid  in  1  a serial config bit is offered.
- cfg_data  in  1  the config bit; frame is sent LSB first, context 0 first.
- cfg_ready  out  1  loader accepts the bit this cycle.
- cfg_abort  in  1  discards the partially shifted frame.
- cfg_done  out  1  one-cycle pulse when a frame commits to the active bank.
- cfg_err  out  1  sticky flag: a committed frame contained an opcode > MAX_OP.
- configured  out  1  at least one frame has committed since reset.
- run  in  1  enables context stepping.
- step  in  1  advances to the next context when run=1.
- ctx_idx  out  log2(NUM_CTX)  index of the active context.
- select  out  SEL_W  opcode for the function unit; equals active[ctx_idx].

## Operation
- Frame length is F = NUM_CTX*SEL_W bits (16 by default). Bit k of the frame goes to bit k%SEL_W of context k/SEL_W.
- A transfer occurs when cfg_valid && cfg_ready. cfg_ready is always 1 except in the cycle where cfg_abort=1.
- The shadow shift register and bit counter (0..F-1) advance once per transfer.
- On the transfer of bit F-1 (the commit):
  - the shadow bank is copied to the active bank on the next edge;
  - the bit counter wraps to 0;
  - ctx_idx is set to 0;
  - configured is set to 1;
  - cfg_done pulses.
- Opcode sanitising: at commit, any context > MAX_OP is written to the active bank as 0 (add), and cfg_err is set. cfg_err clears only on reset.
- cfg_abort=1 clears the bit counter and shadow bank. The active bank, ctx_idx, configured and cfg_err are unchanged. Abort takes priority over a simultaneous cfg_valid, and no transfer occurs in that cycle.
- Stepping: when run && step, ctx_idx increments, wrapping from NUM_CTX-1 to 0. step is ignored when run=0. Stepping is allowed before the first commit and cycles through the all-zero bank.
- Commit and step in the same cycle: commit wins and ctx_idx becomes 0.
- select is combinational from the registered active bank and ctx_idx. There is no combinational path from the cfg_* or step inputs to select.
- Internal states:
  - EMPTY: configured=0, counter=0.
  - LOADING: counter≠0.
  - ARMED: configured=1, counter=0.
  - Transitions:
    - EMPTY or ARMED → LOADING on the first transfer.
    - LOADING → ARMED on commit.
    - LOADING → EMPTY or ARMED on cfg_abort, depending on configured.

## Timing
- Reset values:
  - outputs: cfg_ready=1, cfg_done=0, cfg_err=0, configured=0, ctx_idx=0, select=0;
  - internal: active bank all 0, shadow bank 0, counter 0.
- Reset asserted mid-frame discards all partial and active state immediately, without waiting for a clock edge.
- Load throughput is one bit per cycle. Minimum frame time is F cycles.
- Commit latency: last bit accepted at edge N → cfg_done=1, new select and ctx_idx=0 visible after edge N, for exactly one cycle.
- Step latency: step sampled at edge N → new ctx_idx and select valid after edge N.
- Back-to-back frames need no idle cycle. The first bit of the next frame may be transferred in the cycle after the commit.

## Test plan
- Reset, then idle for 5 cycles → select=0, ctx_idx=0, configured=0, cfg_err=0, cfg_ready=1.
- Shift word 0x4921 LSB first over 16 valid cycles, then pulse step three times with run=1 → cfg_done pulses once, after the 16th bit. select sequence is 1, 2, 9, 4, and a 4th step wraps back to 1.
- Shift 0x4921 with cfg_valid toggling every other cycle, while run=1 and step=1 every cycle on a prior bank → old bank keeps cycling during the load. At commit, ctx_idx=0 and select=1.
- Frame 0x0F35 → active bank is {5, 3, 0, 0}: context 2 value 0xF is sanitised to 0 and cfg_err=1. cfg_err stays 1 after a following clean frame 0x1111.
- After committing 0x4921, send 7 bits and assert cfg_abort, then send a full frame 0x0876 → the abort cycle shows cfg_ready=0 and no state change. The final bank is {6, 7, 8, 0} with no misalignment.
- Assert rst_n=0 asynchronously mid-frame and mid-run → all outputs take reset values before the next clock edge. The next frame loads correctly from bit 0.
